// File: rtl/inc_share_arbiter_if.sv
// Request/response bundle for the shared increment/decrement unit.
// Master is the requester/consumer side; slave is the arbiter.
interface inc_share_arbiter_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREQ  = 3,
   parameter int unsigned IDW   = 2
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_dec;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_wrap;

   modport master (
      output req_valid, req_dec, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_wrap
   );

   modport slave (
      input  req_valid, req_dec, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_wrap
   );
endinterface

// File: rtl/inc_share_arbiter.sv
// Round-robin arbiter sharing one registered +/-1 unit among NREQ requesters,
// with a one-entry tagged result register.
module inc_share_arbiter #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREQ  = 3,
   parameter int unsigned IDW   = 2
) (
   input  logic               clk,
   input  logic               rst,
   inc_share_arbiter_if.slave bus,
   output logic               busy
);
   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   gnt_idx_c, cand_c;
   logic [NREQ-1:0]  grant_c;
   logic             found_c, accept_c, load_c;
   logic [WIDTH-1:0] ops_c [NREQ];
   logic [WIDTH-1:0] op_c, res_c;
   logic             dec_c, wrap_c;
   logic [IDW-1:0]   rsp_id_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             rsp_wrap_q;

   for (genvar g = 0; g < NREQ; g++) begin : g_ops
      assign ops_c[g] = bus.req_data[g*WIDTH +: WIDTH];
   end

   // First valid requester scanning upward from rr_ptr, wrapping modulo NREQ
   always_comb begin
      grant_c   = '0;
      gnt_idx_c = '0;
      found_c   = 1'b0;
      cand_c    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand_c = IDW'((32'(rr_ptr_q) + k) % NREQ);
         if (!found_c && bus.req_valid[cand_c]) begin
            found_c   = 1'b1;
            gnt_idx_c = cand_c;
         end
      end
      grant_c[gnt_idx_c] = found_c;
   end

   assign accept_c      = !rst && ((state_q == S_EMPTY) || bus.rsp_ready) && found_c;
   assign bus.req_ready = {NREQ{accept_c}} & grant_c;

   assign op_c   = ops_c[gnt_idx_c];
   assign dec_c  = bus.req_dec[gnt_idx_c];
   assign res_c  = dec_c ? (op_c - WIDTH'(1)) : (op_c + WIDTH'(1));
   assign wrap_c = dec_c ? (op_c == '0) : (op_c == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_EMPTY;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_EMPTY: if (accept_c) state_d = S_FULL;
         S_FULL:  if (bus.rsp_ready && !accept_c) state_d = S_EMPTY;
         default: state_d = S_EMPTY;
      endcase
   end

   // Load the result register and advance the pointer past the winner
   always_comb begin
      load_c   = 1'b0;
      rr_ptr_d = rr_ptr_q;
      if (accept_c) begin
         load_c   = 1'b1;
         rr_ptr_d = IDW'((32'(gnt_idx_c) + 32'd1) % NREQ);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
         rsp_wrap_q <= 1'b0;
      end else if (load_c) begin
         rsp_id_q   <= gnt_idx_c;
         rsp_data_q <= res_c;
         rsp_wrap_q <= wrap_c;
      end
   end

   assign bus.rsp_valid = (state_q == S_FULL);
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_wrap  = rsp_wrap_q;
   assign busy          = (state_q == S_FULL);
endmodule

// File: tb/tb_inc_share_arbiter.sv
// Scoreboard bench for inc_share_arbiter: a request-level model predicts grants
// and queues expected results; a negedge monitor checks the response side.
module tb_inc_share_arbiter;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned NREQ  = 3;
   localparam int unsigned IDW   = 2;

   typedef struct packed {
      logic [IDW-1:0]   id;
      logic [WIDTH-1:0] data;
      logic             wrap;
   } rsp_t;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   inc_share_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

   inc_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   rsp_t exp_q[$];
   bit   mon_en = 1'b0;

   // Requester / consumer intent for the next cycle
   bit               rst_v;
   bit               rdy_v;
   bit               pend  [NREQ];
   bit               dec_v [NREQ];
   logic [WIDTH-1:0] op_v  [NREQ];
   int               ptr_m = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   rsp_t got;
   always @(negedge clk) begin
      if (mon_en) begin
         check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_q.size() != 0));
         check("busy", 64'(busy), 64'(exp_q.size() != 0));
         if (bus.rsp_valid && exp_q.size() != 0) begin
            got.id   = bus.rsp_id;
            got.data = bus.rsp_data;
            got.wrap = bus.rsp_wrap;
            check("rsp_payload", 64'(got), 64'(exp_q[0]));
            if (bus.rsp_ready) void'(exp_q.pop_front());
         end
      end
   end

   function automatic rsp_t predict(input int id, input logic [WIDTH-1:0] op, input bit dec);
      rsp_t r;
      int   v;
      v      = dec ? int'(op) - 1 : int'(op) + 1;
      r.id   = IDW'(id);
      r.wrap = (v < 0) || (v > 65535);
      r.data = WIDTH'(v & 32'hFFFF);
      return r;
   endfunction

   // One clock: drive intent after the edge, predict the grant, queue the result
   task automatic step();
      int               g;
      logic [NREQ-1:0]  exp_rdy;
      @(posedge clk);
      #1;
      rst           = rst_v;
      bus.rsp_ready = rdy_v;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i]                 = pend[i];
         bus.req_dec[i]                   = dec_v[i];
         bus.req_data[i*WIDTH +: WIDTH]   = op_v[i];
      end
      @(negedge clk);
      #1;
      g = -1;
      if (!rst_v && exp_q.size() == 0)
         for (int k = 0; k < NREQ; k++)
            if (g < 0 && pend[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      if (rst_v) begin
         exp_q.delete();
         ptr_m = 0;
      end else if (g >= 0) begin
         exp_q.push_back(predict(g, op_v[g], dec_v[g]));
         ptr_m   = (g + 1) % NREQ;
         pend[g] = 1'b0;
      end
   endtask

   task automatic set_req(input int i, input logic [WIDTH-1:0] op, input bit dec);
      pend[i]  = 1'b1;
      op_v[i]  = op;
      dec_v[i] = dec;
   endtask

   function automatic logic [WIDTH-1:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         default: return WIDTH'($urandom);
      endcase
   endfunction

   initial begin
      rst           = 1'b1;
      bus.rsp_ready = 1'b0;
      bus.req_valid = '0;
      bus.req_dec   = '0;
      bus.req_data  = '0;
      rst_v = 1'b1;
      rdy_v = 1'b1;
      set_req(0, 16'h000B, 1'b0);
      set_req(1, 16'h0010, 1'b1);
      set_req(2, 16'hFFFF, 1'b0);

      // Reset held two cycles with everyone requesting
      step();
      mon_en = 1'b1;
      step();
      check("reset_rsp_data", 64'(bus.rsp_data), 64'h0);
      check("reset_rsp_id", 64'(bus.rsp_id), 64'h0);
      check("reset_rsp_wrap", 64'(bus.rsp_wrap), 64'h0);

      // Release: 0 (0x000B inc), 1 (0x0010 dec), 2 (0xFFFF inc) in order
      rst_v = 1'b0;
      repeat (3) step();
      set_req(0, 16'h0000, 1'b1);
      step();
      set_req(1, 16'h000F, 1'b0);
      step();
      repeat (2) step();

      // Continuous round-robin with all three requesting
      for (int c = 0; c < 9; c++) begin
         for (int i = 0; i < NREQ; i++) if (!pend[i]) set_req(i, rand_op(), 1'($urandom));
         step();
      end

      // Backpressure: hold the result four cycles, then release
      rdy_v = 1'b0;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < NREQ; i++) if (!pend[i]) set_req(i, rand_op(), 1'($urandom));
         step();
      end
      rdy_v = 1'b1;
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < NREQ; i++) if (!pend[i]) set_req(i, rand_op(), 1'($urandom));
         step();
      end

      // Drain, then reset while requester 2's result is held
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      repeat (3) step();
      set_req(2, 16'h1234, 1'b0);
      step();
      rst_v = 1'b1;
      rdy_v = 1'b0;
      step();
      rst_v = 1'b0;
      rdy_v = 1'b1;
      set_req(1, 16'h0100, 1'b1);
      set_req(2, 16'h0200, 1'b0);
      repeat (4) step();

      // Randomized traffic with drops, backpressure and occasional reset
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) set_req(i, rand_op(), 1'($urandom));
            else if (pend[i] && $urandom_range(0, 49) == 0) pend[i] = 1'b0;
         end
         rdy_v = ($urandom_range(0, 3) != 0);
         rst_v = ($urandom_range(0, 199) == 0);
         step();
      end

      rst_v = 1'b0;
      rdy_v = 1'b1;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
